// File: rtl/id_ex_decode_stage.sv
// rtl/id_ex_decode_stage.sv - instruction decode with register file, bypass, early branch/jump and ID/EX register
// Async active-low reset clears the register file, the ID/EX register and the bubble counter.
module id_ex_decode_stage #(
   parameter int DATA_W     = 32,
   parameter int PC_W       = 10,
   parameter int REG_ADDR_W = 5,
   parameter int ZERO_REG   = 1,
   parameter int COUNT_W    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [PC_W-1:0]       in_pc_plus4,
   input  logic [31:0]           in_instr,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   output logic                  id_ready,
   output logic                  branch_taken,
   output logic [PC_W-1:0]       branch_address,
   output logic                  jump,
   output logic [PC_W-1:0]       jump_address,
   output logic                  ex_valid,
   output logic [DATA_W-1:0]     ex_reg1,
   output logic [DATA_W-1:0]     ex_reg2,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [REG_ADDR_W-1:0] ex_dest,
   output logic                  ex_mem_to_reg,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic                  ex_alu_src,
   output logic                  ex_reg_write,
   output logic [1:0]            ex_alu_op,
   output logic [COUNT_W-1:0]    bubble_cnt
);
   localparam int NREGS = 2 ** REG_ADDR_W;

   logic [DATA_W-1:0]     r_regs [NREGS];
   logic [5:0]            w_opcode;
   logic [REG_ADDR_W-1:0] w_rs_addr, w_rt_addr, w_rd_addr, w_dest;
   logic [DATA_W-1:0]     w_reg1, w_reg2, w_imm;
   logic                  w_rs_zero, w_rt_zero, w_wb_ok, w_bubble, w_go;
   logic                  w_reg_dst, w_branch, w_jump, w_mem_to_reg, w_mem_read;
   logic                  w_mem_write, w_alu_src, w_reg_write;
   logic [1:0]            w_alu_op;

   logic                  r_ex_valid, r_mem_to_reg, r_mem_read, r_mem_write, r_alu_src, r_reg_write;
   logic [1:0]            r_alu_op;
   logic [DATA_W-1:0]     r_reg1, r_reg2, r_imm;
   logic [REG_ADDR_W-1:0] r_dest;
   logic [COUNT_W-1:0]    r_bubble_cnt;

   assign w_opcode  = in_instr[31:26];
   assign w_rs_addr = REG_ADDR_W'(in_instr[25:21]);
   assign w_rt_addr = REG_ADDR_W'(in_instr[20:16]);
   assign w_rd_addr = REG_ADDR_W'(in_instr[15:11]);
   assign w_imm     = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
   assign w_dest    = w_reg_dst ? w_rd_addr : w_rt_addr;

   always_comb begin
      w_reg_dst    = 1'b0;
      w_branch     = 1'b0;
      w_jump       = 1'b0;
      w_mem_to_reg = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_alu_src    = 1'b0;
      w_reg_write  = 1'b0;
      w_alu_op     = 2'b00;
      case (w_opcode)
         6'h00: begin w_reg_dst = 1'b1; w_reg_write = 1'b1; w_alu_op = 2'b10; end
         6'h23: begin w_alu_src = 1'b1; w_mem_to_reg = 1'b1; w_mem_read = 1'b1; w_reg_write = 1'b1; end
         6'h2B: begin w_alu_src = 1'b1; w_mem_write = 1'b1; end
         6'h04: begin w_branch = 1'b1; w_alu_op = 2'b01; end
         6'h08: begin w_alu_src = 1'b1; w_reg_write = 1'b1; end
         6'h02: w_jump = 1'b1;
         default: ;
      endcase
   end

   // Hardwired zero register wins over the bypass so a WB to $0 is never visible.
   assign w_rs_zero = (ZERO_REG != 0) && (w_rs_addr == '0);
   assign w_rt_zero = (ZERO_REG != 0) && (w_rt_addr == '0);
   assign w_reg1    = w_rs_zero ? '0 : (wb_we && wb_addr == w_rs_addr) ? wb_data : r_regs[w_rs_addr];
   assign w_reg2    = w_rt_zero ? '0 : (wb_we && wb_addr == w_rt_addr) ? wb_data : r_regs[w_rt_addr];
   assign w_wb_ok   = wb_we && !((ZERO_REG != 0) && (wb_addr == '0));

   assign w_bubble       = stall | flush;
   assign w_go           = in_valid & ~w_bubble;
   assign id_ready       = ~stall;
   assign branch_taken   = w_branch & (w_reg1 == w_reg2) & w_go;
   assign branch_address = in_pc_plus4 + {w_imm[PC_W-3:0], 2'b00};
   assign jump           = w_jump & w_go;
   assign jump_address   = {in_instr[PC_W-3:0], 2'b00};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else if (w_wb_ok) begin
         r_regs[wb_addr] <= wb_data;
      end
   end

   // Bubbles clear only valid and controls; operand fields keep their last value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ex_valid   <= 1'b0;
         r_reg1       <= '0;
         r_reg2       <= '0;
         r_imm        <= '0;
         r_dest       <= '0;
         r_mem_to_reg <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_alu_src    <= 1'b0;
         r_reg_write  <= 1'b0;
         r_alu_op     <= 2'b00;
      end else if (w_bubble) begin
         r_ex_valid   <= 1'b0;
         r_mem_to_reg <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_alu_src    <= 1'b0;
         r_reg_write  <= 1'b0;
         r_alu_op     <= 2'b00;
      end else begin
         r_ex_valid   <= in_valid;
         r_reg1       <= w_reg1;
         r_reg2       <= w_reg2;
         r_imm        <= w_imm;
         r_dest       <= w_dest;
         r_mem_to_reg <= in_valid & w_mem_to_reg;
         r_mem_read   <= in_valid & w_mem_read;
         r_mem_write  <= in_valid & w_mem_write;
         r_alu_src    <= in_valid & w_alu_src;
         r_reg_write  <= in_valid & w_reg_write;
         r_alu_op     <= in_valid ? w_alu_op : 2'b00;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bubble_cnt <= '0;
      end else if (w_bubble && (r_bubble_cnt != {COUNT_W{1'b1}})) begin
         r_bubble_cnt <= r_bubble_cnt + COUNT_W'(1);
      end
   end

   assign ex_valid      = r_ex_valid;
   assign ex_reg1       = r_reg1;
   assign ex_reg2       = r_reg2;
   assign ex_imm        = r_imm;
   assign ex_dest       = r_dest;
   assign ex_mem_to_reg = r_mem_to_reg;
   assign ex_mem_read   = r_mem_read;
   assign ex_mem_write  = r_mem_write;
   assign ex_alu_src    = r_alu_src;
   assign ex_reg_write  = r_reg_write;
   assign ex_alu_op     = r_alu_op;
   assign bubble_cnt    = r_bubble_cnt;
endmodule

// File: tb/tb_id_ex_decode_stage.sv
// tb/tb_id_ex_decode_stage.sv - randomized and directed bench for id_ex_decode_stage
// A second instance with COUNT_W=3 shares the stimulus to exercise counter saturation.
module tb_id_ex_decode_stage;
   logic        clk = 1'b0;
   logic        reset, in_valid, stall, flush, wb_we;
   logic [9:0]  in_pc_plus4;
   logic [31:0] in_instr, wb_data;
   logic [4:0]  wb_addr;

   logic        id_ready, branch_taken, jump, ex_valid;
   logic [9:0]  branch_address, jump_address;
   logic [31:0] ex_reg1, ex_reg2, ex_imm;
   logic [4:0]  ex_dest;
   logic        ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write;
   logic [1:0]  ex_alu_op;
   logic [15:0] bubble_cnt;

   logic        s_id_ready, s_branch_taken, s_jump, s_ex_valid;
   logic [9:0]  s_branch_address, s_jump_address;
   logic [31:0] s_ex_reg1, s_ex_reg2, s_ex_imm;
   logic [4:0]  s_ex_dest;
   logic        s_ex_mem_to_reg, s_ex_mem_read, s_ex_mem_write, s_ex_alu_src, s_ex_reg_write;
   logic [1:0]  s_ex_alu_op;
   logic [2:0]  s_bubble_cnt;

   always #5 clk = ~clk;

   id_ex_decode_stage #(.DATA_W(32), .PC_W(10), .REG_ADDR_W(5), .ZERO_REG(1), .COUNT_W(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc_plus4(in_pc_plus4), .in_instr(in_instr),
      .stall(stall), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .id_ready(id_ready), .branch_taken(branch_taken), .branch_address(branch_address),
      .jump(jump), .jump_address(jump_address), .ex_valid(ex_valid), .ex_reg1(ex_reg1),
      .ex_reg2(ex_reg2), .ex_imm(ex_imm), .ex_dest(ex_dest), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
      .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op), .bubble_cnt(bubble_cnt));

   id_ex_decode_stage #(.DATA_W(32), .PC_W(10), .REG_ADDR_W(5), .ZERO_REG(1), .COUNT_W(3)) dut_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc_plus4(in_pc_plus4), .in_instr(in_instr),
      .stall(stall), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .id_ready(s_id_ready), .branch_taken(s_branch_taken), .branch_address(s_branch_address),
      .jump(s_jump), .jump_address(s_jump_address), .ex_valid(s_ex_valid), .ex_reg1(s_ex_reg1),
      .ex_reg2(s_ex_reg2), .ex_imm(s_ex_imm), .ex_dest(s_ex_dest), .ex_mem_to_reg(s_ex_mem_to_reg),
      .ex_mem_read(s_ex_mem_read), .ex_mem_write(s_ex_mem_write), .ex_alu_src(s_ex_alu_src),
      .ex_reg_write(s_ex_reg_write), .ex_alu_op(s_ex_alu_op), .bubble_cnt(s_bubble_cnt));

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: architectural register array plus the expected EX slot contents.
   logic [31:0] m_regs [32];
   logic        m_valid;
   logic [31:0] m_r1, m_r2, m_imm;
   logic [4:0]  m_dest;
   logic [6:0]  m_ctl;      // {mem_to_reg, mem_read, mem_write, alu_src, reg_write, alu_op}
   int          m_cnt, m_cnt_sat;
   logic        last_bt, last_j;
   logic [9:0]  last_ba, last_ja;

   function automatic logic [31:0] mread(input int a);
      if (a == 0) return 32'h0;
      if (wb_we && int'(wb_addr) == a) return wb_data;
      return m_regs[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_valid = 1'b0; m_r1 = '0; m_r2 = '0; m_imm = '0; m_dest = '0; m_ctl = '0;
      m_cnt = 0; m_cnt_sat = 0;
   endtask

   task automatic check_ex(input string pfx);
      chk({pfx, "_valid"}, {31'h0, ex_valid}, {31'h0, m_valid});
      chk({pfx, "_reg1"}, ex_reg1, m_r1);
      chk({pfx, "_reg2"}, ex_reg2, m_r2);
      chk({pfx, "_imm"}, ex_imm, m_imm);
      chk({pfx, "_dest"}, {27'h0, ex_dest}, {27'h0, m_dest});
      chk({pfx, "_ctl"}, {25'h0, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op},
          {25'h0, m_ctl});
      chk({pfx, "_cnt"}, {16'h0, bubble_cnt}, m_cnt);
      chk({pfx, "_cnt_sat"}, {29'h0, s_bubble_cnt}, m_cnt_sat);
   endtask

   // One cycle: inputs are already applied; check combinational outputs, clock, check EX slot.
   task automatic step();
      int op, rs, rt, simm;
      logic [31:0] r1, r2;
      logic [6:0] ctl;
      logic rdst, br, jmp, go;
      op = int'(in_instr[31:26]); rs = int'(in_instr[25:21]); rt = int'(in_instr[20:16]);
      simm = int'($signed(in_instr[15:0]));
      r1 = mread(rs); r2 = mread(rt);
      rdst = 0; br = 0; jmp = 0;
      case (op)
         'h00: begin ctl = 7'b0000110; rdst = 1; end
         'h23: ctl = 7'b1101100;
         'h2B: ctl = 7'b0011000;
         'h04: begin ctl = 7'b0000001; br = 1; end
         'h08: ctl = 7'b0001100;
         'h02: begin ctl = 7'b0000000; jmp = 1; end
         default: ctl = 7'b0000000;
      endcase
      go = in_valid && !stall && !flush;
      #1;
      last_bt = branch_taken; last_ba = branch_address; last_j = jump; last_ja = jump_address;
      chk("id_ready", {31'h0, id_ready}, {31'h0, !stall});
      chk("branch_taken", {31'h0, branch_taken}, {31'h0, br && (r1 == r2) && go});
      chk("branch_address", {22'h0, branch_address}, (int'(in_pc_plus4) + simm * 4) & 'h3FF);
      chk("jump", {31'h0, jump}, {31'h0, jmp && go});
      chk("jump_address", {22'h0, jump_address}, (in_instr % 256) * 4);
      @(posedge clk);
      if (stall || flush) begin
         m_valid = 0; m_ctl = '0;
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt_sat < 7) m_cnt_sat++;
      end else begin
         m_valid = in_valid; m_r1 = r1; m_r2 = r2; m_imm = 32'(simm);
         m_dest = rdst ? in_instr[15:11] : in_instr[20:16];
         m_ctl = in_valid ? ctl : 7'b0;
      end
      if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
      #1;
      check_ex("ex");
   endtask

   task automatic drive(input logic v, input logic [9:0] pc, input logic [31:0] ins, input logic st,
                        input logic fl, input logic we, input logic [4:0] wa, input logic [31:0] wd);
      in_valid = v; in_pc_plus4 = pc; in_instr = ins; stall = st; flush = fl;
      wb_we = we; wb_addr = wa; wb_data = wd;
      step();
   endtask

   task automatic check_all_zero(input string pfx);
      chk({pfx, "_valid"}, {31'h0, ex_valid}, 32'h0);
      chk({pfx, "_regs"}, ex_reg1 | ex_reg2 | ex_imm, 32'h0);
      chk({pfx, "_dest_ctl"}, {20'h0, ex_dest, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src,
                               ex_reg_write, ex_alu_op}, 32'h0);
      chk({pfx, "_cnt"}, {16'h0, bubble_cnt}, 32'h0);
      chk({pfx, "_cnt_sat"}, {29'h0, s_bubble_cnt}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int base;
      int ops[6];
      ops = '{'h00, 'h23, 'h2B, 'h04, 'h08, 'h02};
      reset = 0; in_valid = 0; in_pc_plus4 = '0; in_instr = '0; stall = 0; flush = 0;
      wb_we = 0; wb_addr = '0; wb_data = '0;
      model_reset();
      #22;
      check_all_zero("init");
      @(posedge clk); #1;
      reset = 1;

      // Bypass into EX operands.
      drive(1, 10'h0, 32'h00602020, 0, 0, 1, 5'd3, 32'hDEADBEEF);
      chk("tp2_reg1", ex_reg1, 32'hDEADBEEF);
      chk("tp2_dest", {27'h0, ex_dest}, 32'd4);
      chk("tp2_rw_op", {29'h0, ex_reg_write, ex_alu_op}, 32'b110);

      // Branch equality, taken and not taken.
      drive(1, 10'h0, 32'hFC000000, 0, 0, 1, 5'd1, 32'd7);
      drive(1, 10'h0, 32'hFC000000, 0, 0, 1, 5'd2, 32'd7);
      drive(1, 10'h040, 32'h1022FFFE, 0, 0, 0, 5'd0, 32'd0);
      chk("tp3_taken", {31'h0, last_bt}, 32'd1);
      chk("tp3_addr", {22'h0, last_ba}, 32'h038);
      drive(1, 10'h040, 32'h1022FFFE, 0, 0, 1, 5'd2, 32'd8);
      chk("tp3_not_taken", {31'h0, last_bt}, 32'd0);

      // Stall, release, combined stall+flush.
      base = int'(bubble_cnt);
      drive(1, 10'h0, 32'h8C220004, 1, 0, 0, 5'd0, 32'd0);
      chk("tp4_stall_valid", {31'h0, ex_valid}, 32'd0);
      chk("tp4_stall_mr", {31'h0, ex_mem_read}, 32'd0);
      chk("tp4_stall_cnt", {16'h0, bubble_cnt}, base + 1);
      drive(1, 10'h0, 32'h8C220004, 0, 0, 0, 5'd0, 32'd0);
      chk("tp4_lw_ctl", {30'h0, ex_mem_read, ex_alu_src}, 32'b11);
      chk("tp4_lw_imm", ex_imm, 32'd4);
      chk("tp4_lw_dest", {27'h0, ex_dest}, 32'd2);
      drive(1, 10'h0, 32'h8C220004, 1, 1, 0, 5'd0, 32'd0);
      chk("tp4_both_cnt", {16'h0, bubble_cnt}, base + 2);

      // Zero register, branch target wrap, jump target.
      drive(1, 10'h0, 32'h00002020, 0, 0, 1, 5'd0, 32'h55);
      chk("tp5_zero", ex_reg1, 32'h0);
      drive(1, 10'h0, 32'h00002020, 0, 0, 0, 5'd0, 32'h0);
      chk("tp5_zero_after", ex_reg1, 32'h0);
      drive(1, 10'h3FC, 32'h10000001, 0, 0, 0, 5'd0, 32'd0);
      chk("tp5_wrap", {22'h0, last_ba}, 32'h000);
      drive(1, 10'h0, 32'h08000010, 0, 0, 0, 5'd0, 32'd0);
      chk("tp5_jump", {31'h0, last_j}, 32'd1);
      chk("tp5_jaddr", {22'h0, last_ja}, 32'h040);

      // Saturation of the narrow counter.
      for (int i = 0; i < 10; i++) drive(1, 10'h0, 32'h00000000, 1, 0, 0, 5'd0, 32'd0);
      chk("tp6_sat", {29'h0, s_bubble_cnt}, 32'd7);

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         logic [31:0] ins;
         int op;
         op = ($urandom_range(0, 6) == 6) ? int'($urandom_range(0, 63)) : ops[$urandom_range(0, 5)];
         ins = $urandom;
         ins[31:26] = 6'(op);
         ins[25:21] = 5'($urandom_range(0, 7));
         ins[20:16] = 5'($urandom_range(0, 7));
         drive($urandom_range(0, 9) != 0, 10'($urandom), ins, $urandom_range(0, 7) == 0,
               $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
               ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3)));
      end

      // Asynchronous reset mid-run.
      drive(1, 10'h0, 32'h00221820, 1, 0, 1, 5'd1, 32'd7);
      drive(1, 10'h0, 32'h00221820, 0, 0, 0, 5'd0, 32'd0);
      chk("tp1_pre_rw", {31'h0, ex_reg_write}, 32'd1);
      #2;
      reset = 0;
      #1;
      check_all_zero("tp1_reset");
      model_reset();
      @(posedge clk); #1;
      reset = 1;
      drive(1, 10'h0, 32'h00222020, 0, 0, 0, 5'd0, 32'd0);
      chk("tp1_rf_cleared", ex_reg1, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/id_ex_decode_stage.md
Name: id_ex_decode_stage

Overview:
Parametrised instruction-decode stage with an integrated ID/EX pipeline register, internal register file with write-through bypass, and early branch/jump resolution. Sits between the IF/ID register and the EX stage. Adds behaviour beyond the single-cycle decode:
- registered EX-side outputs
- stall and flush bubble insertion
- WB-to-ID bypass
- a saturating bubble counter

Parameters:
DATA_W, 32, datapath and register width
PC_W, 10, PC/address width (must be >= 3)
REG_ADDR_W, 5, register address width; register file has 2**REG_ADDR_W entries
ZERO_REG, 1, 1 = register 0 reads zero and ignores writes
COUNT_W, 16, width of bubble counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  IF/ID holds a valid instruction
in_pc_plus4  in  PC_W  PC+4 of the instruction
in_instr  in  32  instruction word
stall  in  1  data-hazard hold from hazard unit
flush  in  1  control-hazard squash
wb_we  in  1  write-back enable
wb_addr  in  REG_ADDR_W  write-back register
wb_data  in  DATA_W  write-back data
id_ready  out  1  ID accepts instruction this cycle (= ~stall)
branch_taken  out  1  combinational, beq resolved taken
branch_address  out  PC_W  combinational branch target
jump  out  1  combinational, j decoded
jump_address  out  PC_W  combinational jump target
ex_valid  out  1  registered, EX slot holds real instruction
ex_reg1, ex_reg2  out  DATA_W  registered operands
ex_imm  out  DATA_W  registered sign-extended immediate
ex_dest  out  REG_ADDR_W  registered destination register
ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write  out  1 each  registered controls
ex_alu_op  out  2  registered ALU op
bubble_cnt  out  COUNT_W  saturating bubble count

Behaviour:
Decode, opcode = instr[31:26]. Signals not listed are 0.
- 0x00 R-type: reg_dst=1, reg_write=1, alu_op=10
- 0x23 lw: alu_src=1, mem_to_reg=1, mem_read=1, reg_write=1, alu_op=00
- 0x2B sw: alu_src=1, mem_write=1, alu_op=00
- 0x04 beq: branch=1, alu_op=01
- 0x08 addi: alu_src=1, reg_write=1, alu_op=00
- 0x02 j: jump=1
- any other opcode: all controls 0, treated as NOP

Register file:
- Async reset clears all entries to 0.
- Writes on the rising edge when wb_we=1. Writes to addr 0 are dropped when ZERO_REG=1.
- Read ports: rs = instr[25:21], rt = instr[20:16], truncated/zero-extended to REG_ADDR_W.
- Bypass: if wb_we=1 and wb_addr equals the read address (and the address is nonzero when ZERO_REG=1), the read returns wb_data in the same cycle.

Immediate and targets:
- imm = sign-extend instr[15:0] to DATA_W.
- dest = rd (instr[15:11]) when reg_dst=1, else rt.
- branch_address = (in_pc_plus4 + (imm << 2)) truncated to PC_W; modulo wrap, no overflow flag.
- jump_address = {instr[PC_W-3:0], 2'b00}.
- Branch equality is full DATA_W compare of the bypassed reg1 and reg2.

Qualification:
- branch_taken = branch & equal & in_valid & ~stall & ~flush.
- jump = decoded jump & in_valid & ~stall & ~flush.

ID/EX register, priority reset > flush > stall > load:
- reset low: ex_valid, all ex_* outputs and bubble_cnt = 0, immediately and asynchronously.
- flush=1: bubble. ex_valid=0 and all ex controls 0; data fields hold.
- stall=1 (flush=0): same bubble as flush. IF/ID hold is the upstream block's responsibility.
- otherwise: load decoded values; ex_valid=in_valid. When in_valid=0, controls load 0.

Bubble counter:
- Increments by 1 each rising edge on which stall|flush is 1.
- Saturates at 2**COUNT_W-1.
- Cleared only by reset.

Timing:
- Latency from in_instr to ex_* is 1 cycle.
- Same-cycle WB write and ID read: the bypass value is captured into ex_reg*.

Test Plan:
1. Reset: drive reset=0 mid-run with ex_reg_write=1 and bubble_cnt=5 -> all ex_* and bubble_cnt = 0 before the next edge; register file reads 0.
2. Bypass: wb_we=1, wb_addr=3, wb_data=0xDEADBEEF, same cycle in_instr=add $4,$3,$0 (0x00602020) -> next cycle ex_reg1=0xDEADBEEF, ex_dest=4, ex_reg_write=1, ex_alu_op=10.
3. Branch: $1=$2=7, in_pc_plus4=0x040, beq $1,$2,-2 (0x1022FFFE) -> branch_taken=1, branch_address=0x038. With $2=8 -> branch_taken=0.
4. Stall/flush: lw (0x8C220004) with stall=1 -> ex_valid=0, ex_mem_read=0, bubble_cnt+1. Release stall -> ex_mem_read=1, ex_alu_src=1, ex_imm=4, ex_dest=2. stall=1 and flush=1 together -> one bubble, counter +1 (not +2).
5. Zero register / wrap: wb write 0x55 to addr 0 -> reading $0 returns 0. beq with in_pc_plus4=0x3FC and imm=+1 -> branch_address=0x000. j 0x08000010 -> jump_address=0x040.
6. Saturation: COUNT_W=3 with 10 stall cycles -> bubble_cnt stops at 7.
